// File: rtl/tpu_pkg.sv
// tpu_pkg: address map, default geometry and FSM state type shared by the TPU host initiator
package tpu_pkg;
   localparam int DEF_DIM         = 8;
   localparam int DEF_BITS_AB     = 8;
   localparam int DEF_BITS_C      = 16;
   localparam int DEF_ADDRW       = 16;
   localparam int DEF_DATAW       = 64;
   localparam int A_BASE          = 'h100;
   localparam int B_BASE          = 'h200;
   localparam int C_BASE          = 'h300;
   localparam int START_ADDR      = 'h400;
   localparam int C_WORDS_PER_ROW = DEF_DIM * DEF_BITS_C / DEF_DATAW;
   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, READ_C, DONE} state_t;
endpackage

// File: rtl/tpu_rd_slot.sv
// tpu_rd_slot: single-entry read-capture register presenting TPU read data on a valid/ready stream
//   clk, rst_n   clock, async active-low reset
//   issue_i      a read address is on the bus this cycle
//   rd_data_i    TPU read data, valid the cycle after issue_i
//   out_ready_i  downstream ready
//   out_valid_o  captured word valid
//   out_data_o   captured word, held until handshaken
//   permit_o     a new read may be issued this cycle
module tpu_rd_slot #(
   parameter int DATAW = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_i,
   input  logic [DATAW-1:0] rd_data_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [DATAW-1:0] out_data_o,
   output logic             permit_o
);
   logic pending_q;
   // Only one read in flight, and only when the slot will be free by capture time.
   assign permit_o = !pending_q && (!out_valid_o || out_ready_i);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= 1'b0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else begin
         pending_q <= issue_i;
         // A capture wins over a same-cycle handshake: the new word replaces the old.
         if (pending_q) begin
            out_valid_o <= 1'b1;
            out_data_o  <= rd_data_i;
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/tpu_host_initiator.sv
// tpu_host_initiator: bus initiator that loads A/B, starts the TPU, waits, and streams C back out
//   clk, rst_n             clock, async active-low reset
//   job_start/busy/done    job control: start pulse, busy level, one-cycle done pulse
//   in_valid/ready/data    input words: A rows then B rows
//   out_valid/ready/data   C words, row-major, low half of each row first
//   tpu_r_w/addr/dataIn    TPU bus request (1=write); idle bus is r_w=0, addr=0
//   tpu_dataOut            TPU read data, one cycle after the read address
module tpu_host_initiator
   import tpu_pkg::*;
#(
   parameter int DIM            = DEF_DIM,
   parameter int BITS_AB        = DEF_BITS_AB,
   parameter int BITS_C         = DEF_BITS_C,
   parameter int ADDRW          = DEF_ADDRW,
   parameter int DATAW          = DEF_DATAW,
   parameter int COMPUTE_CYCLES = 3 * DIM
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             job_start,
   output logic             job_busy,
   output logic             job_done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic             tpu_r_w,
   output logic [ADDRW-1:0] tpu_addr,
   output logic [DATAW-1:0] tpu_dataIn,
   input  logic [DATAW-1:0] tpu_dataOut
);
   localparam int NW = 2 * DIM;
   localparam int RW = $clog2(DIM);
   localparam int KW = $clog2(NW) + 1;
   localparam int WW = $clog2(COMPUTE_CYCLES + 1);
   if (DIM * BITS_AB != DATAW || DIM * BITS_C != C_WORDS_PER_ROW * DATAW) begin : g_bad_cfg
      $error("tpu_host_initiator: unsupported DIM/BITS_AB/BITS_C/DATAW combination");
   end
   state_t          state_q;
   logic [RW-1:0]   row_q;
   logic [KW-1:0]   iss_q, hs_q;
   logic [WW-1:0]   wait_q;
   logic            busy_q, done_q;
   logic            in_hs, out_hs, issue, permit, start_wr;
   logic [ADDRW-1:0] ld_addr, rd_addr;
   assign job_busy = busy_q;
   assign job_done = done_q;
   assign in_ready = state_q == LOAD_A || state_q == LOAD_B;
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;
   assign start_wr = state_q == START;
   assign issue    = state_q == READ_C && permit && iss_q != KW'(NW);
   assign ld_addr  = ADDRW'((state_q == LOAD_A ? A_BASE : B_BASE) + 8 * int'(row_q));
   assign rd_addr  = ADDRW'(C_BASE + 16 * (int'(iss_q) / C_WORDS_PER_ROW)
                           + 8 * (int'(iss_q) % C_WORDS_PER_ROW));
   // Bus requests are combinational so a load handshake writes in the same cycle.
   assign tpu_r_w    = in_hs || start_wr;
   assign tpu_addr   = in_hs ? ld_addr : start_wr ? ADDRW'(START_ADDR) : issue ? rd_addr : '0;
   assign tpu_dataIn = in_hs ? in_data : start_wr ? DATAW'(1) : '0;
   tpu_rd_slot #(.DATAW(DATAW)) u_rd_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_i     (issue),
      .rd_data_i   (tpu_dataOut),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .permit_o    (permit)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         iss_q   <= '0;
         hs_q    <= '0;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (job_start) begin
               state_q <= LOAD_A;
               row_q   <= '0;
               busy_q  <= 1'b1;
            end
            LOAD_A, LOAD_B: if (in_hs) begin
               row_q <= row_q == RW'(DIM - 1) ? '0 : row_q + RW'(1);
               if (row_q == RW'(DIM - 1)) state_q <= state_q == LOAD_A ? LOAD_B : START;
            end
            START: begin
               state_q <= WAIT;
               wait_q  <= '0;
            end
            WAIT: begin
               wait_q <= wait_q + WW'(1);
               if (wait_q == WW'(COMPUTE_CYCLES - 1)) begin
                  state_q <= READ_C;
                  iss_q   <= '0;
                  hs_q    <= '0;
               end
            end
            READ_C: begin
               if (issue) iss_q <= iss_q + KW'(1);
               if (out_hs) begin
                  hs_q <= hs_q + KW'(1);
                  if (hs_q == KW'(NW - 1)) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
